// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register for the 5-stage RV32I pipeline.
// A one-entry hold buffer keeps a completed fetch while StallF is asserted, so it is not re-issued.
module fetch_stage #(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ready,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output logic            FetchBusy
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0] pcf_q, pcf_d;
  logic            hold_valid_q, hold_valid_d;
  logic [31:0]     hold_instr_q, hold_instr_d;
  logic [31:0]     instr_d_q, instr_d_d;
  logic [XLEN-1:0] pc_d_q, pc_d_d;
  logic [XLEN-1:0] pc_plus4_d_q, pc_plus4_d_d;
  logic            valid_d_q, valid_d_d;

  logic            fetch_avail;
  logic [31:0]     fetch_instr;
  logic [XLEN-1:0] pc_plus4_f;

  assign imem_req    = ~reset & ~hold_valid_q;
  assign imem_addr   = pcf_q & ALIGN_MASK;
  assign FetchBusy   = imem_req & ~imem_ready;
  assign fetch_avail = hold_valid_q | (imem_req & imem_ready);
  assign fetch_instr = hold_valid_q ? hold_instr_q : imem_rdata;
  assign pc_plus4_f  = pcf_q + XLEN'(4);

  // Next-state for PC, hold buffer and IF/ID register
  always_comb begin
    pcf_d        = pcf_q;
    hold_valid_d = hold_valid_q;
    hold_instr_d = hold_instr_q;
    instr_d_d    = instr_d_q;
    pc_d_d       = pc_d_q;
    pc_plus4_d_d = pc_plus4_d_q;
    valid_d_d    = valid_d_q;

    if (PCSrcE) begin
      pcf_d = PCTargetE & ALIGN_MASK;
    end else if (!StallF && fetch_avail) begin
      pcf_d = pc_plus4_f;
    end

    if (PCSrcE) begin
      hold_valid_d = 1'b0;
    end else if (StallF && imem_req && imem_ready) begin
      hold_valid_d = 1'b1;
      hold_instr_d = imem_rdata;
    end else if (!StallF && hold_valid_q) begin
      hold_valid_d = 1'b0;
    end

    // Flush beats stall; an empty fetch slot becomes a bubble
    if (FlushD) begin
      instr_d_d    = NOP_INSTR;
      pc_d_d       = '0;
      pc_plus4_d_d = '0;
      valid_d_d    = 1'b0;
    end else if (StallD) begin
      instr_d_d    = instr_d_q;
    end else if (!StallF && fetch_avail) begin
      instr_d_d    = fetch_instr;
      pc_d_d       = pcf_q;
      pc_plus4_d_d = pc_plus4_f;
      valid_d_d    = 1'b1;
    end else begin
      instr_d_d    = NOP_INSTR;
      pc_d_d       = '0;
      pc_plus4_d_d = '0;
      valid_d_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcf_q        <= RESET_PC;
      hold_valid_q <= 1'b0;
      hold_instr_q <= '0;
      instr_d_q    <= NOP_INSTR;
      pc_d_q       <= '0;
      pc_plus4_d_q <= '0;
      valid_d_q    <= 1'b0;
    end else begin
      pcf_q        <= pcf_d;
      hold_valid_q <= hold_valid_d;
      hold_instr_q <= hold_instr_d;
      instr_d_q    <= instr_d_d;
      pc_d_q       <= pc_d_d;
      pc_plus4_d_q <= pc_plus4_d_d;
      valid_d_q    <= valid_d_d;
    end
  end

  assign InstrD   = instr_d_q;
  assign PCD      = pc_d_q;
  assign PCPlus4D = pc_plus4_d_q;
  assign ValidD   = valid_d_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage; memory returns address-tagged words.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, StallF, StallD, FlushD, PCSrcE, imem_ready;
  logic [31:0] PCTargetE, imem_addr, imem_rdata, InstrD, PCD, PCPlus4D;
  logic        imem_req, ValidD, FetchBusy;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clk = ~clk;

  function automatic logic [31:0] tag(input logic [31:0] a);
    return 32'hC000_0000 | a;
  endfunction

  assign imem_rdata = imem_ready ? tag(imem_addr) : 32'hDEAD_BEEF;

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .StallF     (StallF),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD),
    .FetchBusy  (FetchBusy)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    PCSrcE = 1'b0; PCTargetE = '0; imem_ready = 1'b1;
    step(); step();

    // reset state
    check("rst_req",    32'(imem_req), 32'd0);
    check("rst_addr",   imem_addr, 32'h0);
    check("rst_instr",  InstrD, NOP);
    check("rst_valid",  32'(ValidD), 32'd0);
    check("rst_pcd",    PCD, 32'h0);
    check("rst_busy",   32'(FetchBusy), 32'd0);

    // streaming fetch, zero wait states
    reset = 1'b0; #1;
    check("s0_req",  32'(imem_req), 32'd1);
    check("s0_addr", imem_addr, 32'h0);
    step();
    check("s1_addr",  imem_addr, 32'h4);
    check("s1_instr", InstrD, tag(32'h0));
    check("s1_valid", 32'(ValidD), 32'd1);
    check("s1_pcd",   PCD, 32'h0);
    check("s1_pc4d",  PCPlus4D, 32'h4);
    step();
    check("s2_addr",  imem_addr, 32'h8);
    check("s2_instr", InstrD, tag(32'h4));
    check("s2_pcd",   PCD, 32'h4);

    // three wait states at 0x8
    imem_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      check("ws_busy", 32'(FetchBusy), 32'd1);
      check("ws_addr", imem_addr, 32'h8);
      step();
      check("ws_valid", 32'(ValidD), 32'd0);
      check("ws_instr", InstrD, NOP);
    end
    imem_ready = 1'b1; #1;
    check("ws_done_busy", 32'(FetchBusy), 32'd0);
    step();
    check("ws_instr8", InstrD, tag(32'h8));
    check("ws_pcd8",   PCD, 32'h8);
    check("ws_addr12", imem_addr, 32'hC);

    // stall two cycles, fetch completes on the first
    StallF = 1'b1; StallD = 1'b1; #1;
    check("st_req0", 32'(imem_req), 32'd1);
    step();
    imem_ready = 1'b0; #1;
    check("st_req1",   32'(imem_req), 32'd0);
    check("st_busy1",  32'(FetchBusy), 32'd0);
    check("st_instr1", InstrD, tag(32'h8));
    check("st_pcd1",   PCD, 32'h8);
    step();
    check("st_req2",   32'(imem_req), 32'd0);
    check("st_instr2", InstrD, tag(32'h8));
    StallF = 1'b0; StallD = 1'b0; #1;
    check("st_rel_req", 32'(imem_req), 32'd0);
    step();
    check("st_instr12", InstrD, tag(32'hC));
    check("st_pcd12",   PCD, 32'hC);
    check("st_valid",   32'(ValidD), 32'd1);
    check("st_req3",    32'(imem_req), 32'd1);
    check("st_addr16",  imem_addr, 32'h10);

    // redirect + flush while the hold buffer is full (flush also beats StallD)
    imem_ready = 1'b1; StallF = 1'b1; StallD = 1'b1;
    step();
    imem_ready = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h0000_0102; FlushD = 1'b1; #1;
    check("rd_req_held", 32'(imem_req), 32'd0);
    step();
    PCSrcE = 1'b0; FlushD = 1'b0; StallF = 1'b0; StallD = 1'b0; #1;
    check("rd_instr", InstrD, NOP);
    check("rd_valid", 32'(ValidD), 32'd0);
    check("rd_pcd",   PCD, 32'h0);
    check("rd_pc4d",  PCPlus4D, 32'h0);
    check("rd_req",   32'(imem_req), 32'd1);
    check("rd_addr",  imem_addr, 32'h100);
    imem_ready = 1'b1;
    step();
    check("rd_instr100", InstrD, tag(32'h100));
    check("rd_pcd100",   PCD, 32'h100);

    // FlushD and StallD together
    FlushD = 1'b1; StallD = 1'b1;
    step();
    FlushD = 1'b0; StallD = 1'b0; #1;
    check("fs_instr", InstrD, NOP);
    check("fs_valid", 32'(ValidD), 32'd0);
    check("fs_addr",  imem_addr, 32'h108);

    // redirect to top of address space with data returning the same cycle
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC; FlushD = 1'b1;
    step();
    PCSrcE = 1'b0; FlushD = 1'b0; #1;
    check("wr_addr",  imem_addr, 32'hFFFF_FFFC);
    check("wr_valid", 32'(ValidD), 32'd0);
    check("wr_instr", InstrD, NOP);
    step();
    check("wr_pcd",  PCD, 32'hFFFF_FFFC);
    check("wr_pc4d", PCPlus4D, 32'h0);
    check("wr_next", imem_addr, 32'h0);
    step();
    check("wr_addr4", imem_addr, 32'h4);

    // reset during a wait state
    imem_ready = 1'b0;
    step();
    check("rw_busy", 32'(FetchBusy), 32'd1);
    check("rw_addr", imem_addr, 32'h4);
    reset = 1'b1; #1;
    check("rw_req_rst", 32'(imem_req), 32'd0);
    step();
    check("rw_req_hold", 32'(imem_req), 32'd0);
    check("rw_addr0",    imem_addr, 32'h0);
    check("rw_valid",    32'(ValidD), 32'd0);
    reset = 1'b0; #1;
    check("rw_req_up", 32'(imem_req), 32'd1);
    check("rw_busy2",  32'(FetchBusy), 32'd1);
    imem_ready = 1'b1;
    step();
    check("rw_instr0", InstrD, tag(32'h0));
    check("rw_pcd0",   PCD, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
